// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the core memory bus between the fetch (IF) and load/store (LS) ports.
// One transaction in flight at a time. LS has priority, IF has an anti-starvation override, and a flush drops fetch responses.
`default_nettype none
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  output logic                    ls_gnt,
  output logic                    ls_rvalid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    arb_stall
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_if_q, owner_if_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]       bus_be_q, bus_be_d;

  logic ls_sel, if_sel, resp_fire;

  // IF overrides LS only when it has lost STARVE_LIMIT arbitrations in a row
  assign ls_sel    = (state_q == S_IDLE) && ls_req && !(if_req && (starve_q == CNT_MAX));
  assign if_sel    = (state_q == S_IDLE) && !ls_sel && if_req && !flush;
  assign resp_fire = (state_q == S_RESP) && bus_rvalid;

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (ls_sel) begin
          state_d     = S_ADDR;
          owner_if_d  = 1'b0;
          bus_we_d    = ls_we;
          bus_addr_d  = ls_addr;
          bus_wdata_d = ls_wdata;
          bus_be_d    = ls_be;
          if (if_req && (starve_q != CNT_MAX)) starve_d = starve_q + 1'b1;
        end else if (if_sel) begin
          state_d     = S_ADDR;
          owner_if_d  = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_be_d    = '1;
          starve_d    = '0;
        end
      end
      S_ADDR: begin
        if (owner_if_q && flush) drop_d = 1'b1;
        if (bus_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_if_q && flush) drop_d = 1'b1;
        if (bus_rvalid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    bus_req_d = (state_d == S_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_if_q  <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held
  assign ls_gnt    = rst_n && ls_sel;
  assign if_gnt    = rst_n && if_sel;
  assign ls_rvalid = resp_fire && !owner_if_q;
  assign if_rvalid = resp_fire && owner_if_q && !drop_q && !flush;
  assign ls_rdata  = ls_rvalid ? bus_rdata : '0;
  assign if_rdata  = if_rvalid ? bus_rdata : '0;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

  assign arb_stall = rst_n && ((ls_req && !ls_gnt) ||
                               (!owner_if_q && (state_q != S_IDLE) && !ls_rvalid));
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
`default_nettype none
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic clk, rst_n, flush;
  logic if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [3:0] ls_be;
  logic bus_req, bus_we, bus_gnt, bus_rvalid, arb_stall;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [3:0] bus_be;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .arb_stall(arb_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bus slave: grant one cycle after bus_req is seen, respond two cycles after the grant
  logic [DW-1:0] bus_val = '0;
  logic hold_gnt = 1'b0;
  logic spur = 1'b0;
  int n_bus_rv = 0;
  initial begin
    int w, rcnt;
    bit rv_pend;
    w = 0; rcnt = 0; rv_pend = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = 32'hBAD0BAD0;
      if (!rst_n) begin
        rv_pend = 0; w = 0;
      end else if (spur) begin
        bus_gnt = 1; bus_rvalid = 1;
      end else if (rv_pend) begin
        if (rcnt == 0) begin
          bus_rvalid = 1; bus_rdata = bus_val; rv_pend = 0; n_bus_rv++;
        end else rcnt--;
      end else if (bus_req && !hold_gnt) begin
        if (w == 1) begin
          bus_gnt = 1; w = 0; rv_pend = 1; rcnt = 1;
        end else w++;
      end
    end
  end

  // Reference model: one pending transaction described by who owns it and how far it has got
  bit m_busy, m_addr_done, m_is_if, m_killed;
  int m_losses;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic m_we;
  logic [3:0] m_be;

  int cyc = 0;
  int n_if_gnt = 0, n_ls_gnt = 0, n_if_rv = 0, n_ls_rv = 0, n_stall = 0;
  int if_gnt_cyc, ls_gnt_cyc, if_rv_cyc, ls_rv_cyc, rq_cyc;
  logic [DW-1:0] last_if_rdata, last_ls_rdata;
  logic [AW-1:0] rq_addr;
  logic [DW-1:0] rq_wdata;
  logic rq_we;
  logic [3:0] rq_be;
  logic prev_bus_req = 1'b0;

  always @(negedge clk) begin
    bit e_ls_gnt, e_if_gnt, e_if_rv, e_ls_rv, e_stall, deliver;
    if (!rst_n) begin
      m_busy = 0; m_addr_done = 0; m_is_if = 0; m_killed = 0; m_losses = 0;
      m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0;
      chk("reset_outputs_zero", 64'(|{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
          bus_req, bus_we, bus_addr, bus_wdata, bus_be, arb_stall}), 64'd0);
    end else begin
      e_ls_gnt = 0; e_if_gnt = 0;
      if (!m_busy) begin
        if (ls_req && !(if_req && m_losses == LIMIT)) e_ls_gnt = 1;
        else if (if_req && !flush) e_if_gnt = 1;
      end
      deliver = m_busy && m_addr_done && bus_rvalid;
      e_if_rv = deliver && m_is_if && !m_killed && !flush;
      e_ls_rv = deliver && !m_is_if;
      e_stall = (ls_req && !e_ls_gnt) || (m_busy && !m_is_if && !e_ls_rv);
      chk("ls_gnt", 64'(ls_gnt), 64'(e_ls_gnt));
      chk("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
      chk("ls_rvalid", 64'(ls_rvalid), 64'(e_ls_rv));
      chk("if_rvalid", 64'(if_rvalid), 64'(e_if_rv));
      chk("ls_rdata", 64'(ls_rdata), e_ls_rv ? 64'(bus_rdata) : 64'd0);
      chk("if_rdata", 64'(if_rdata), e_if_rv ? 64'(bus_rdata) : 64'd0);
      chk("bus_req", 64'(bus_req), 64'(m_busy && !m_addr_done));
      chk("bus_payload", {bus_we, bus_be, bus_addr}, {m_we, m_be, m_addr});
      chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
      chk("arb_stall", 64'(arb_stall), 64'(e_stall));
      if (m_busy) begin
        if (m_is_if && flush) m_killed = 1;
        if (!m_addr_done) begin
          if (bus_gnt) m_addr_done = 1;
        end else if (bus_rvalid) begin
          m_busy = 0; m_killed = 0;
        end
      end
      if (e_ls_gnt) begin
        m_busy = 1; m_addr_done = 0; m_is_if = 0;
        m_addr = ls_addr; m_we = ls_we; m_wdata = ls_wdata; m_be = ls_be;
        if (if_req) m_losses = (m_losses + 1 > LIMIT) ? LIMIT : m_losses + 1;
      end else if (e_if_gnt) begin
        m_busy = 1; m_addr_done = 0; m_is_if = 1;
        m_addr = if_addr; m_we = 0; m_wdata = '0; m_be = 4'hF;
        m_losses = 0;
      end
    end
    if (if_gnt) begin n_if_gnt++; if_gnt_cyc = cyc; end
    if (ls_gnt) begin n_ls_gnt++; ls_gnt_cyc = cyc; end
    if (if_rvalid) begin n_if_rv++; if_rv_cyc = cyc; last_if_rdata = if_rdata; end
    if (ls_rvalid) begin n_ls_rv++; ls_rv_cyc = cyc; last_ls_rdata = ls_rdata; end
    if (arb_stall) n_stall++;
    if (bus_req && !prev_bus_req) begin
      rq_cyc = cyc; rq_addr = bus_addr; rq_we = bus_we; rq_wdata = bus_wdata; rq_be = bus_be;
    end
    prev_bus_req = bus_req;
    cyc++;
  end

  function automatic int ev_cnt(input int which);
    case (which)
      0: return n_if_gnt;
      1: return n_ls_gnt;
      2: return n_if_rv;
      default: return n_ls_rv;
    endcase
  endfunction

  // Returns at the posedge following the event; inputs may then be changed after #1
  task automatic wait_ev(input int which, input int budget, input string nm);
    int start;
    start = ev_cnt(which);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (ev_cnt(which) != start) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL timeout_%s: no event after %0d cycles", nm, budget);
  endtask

  task automatic drive_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] be);
    ls_req = 1; ls_we = we; ls_addr = a; ls_wdata = d; ls_be = be;
  endtask

  initial begin
    int ls0, rv0, bus0, st0;
    rst_n = 0; flush = 0; if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    #1 if_req = 1; ls_req = 1;
    #11;
    chk("reset_no_gnt", 64'({ls_gnt, if_gnt, arb_stall}), 64'd0);
    if_req = 0; ls_req = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // IF-only fetch
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h100; bus_val = 32'h00000013;
    wait_ev(0, 10, "t1_gnt");
    #1 if_req = 0;
    wait_ev(2, 10, "t1_rv");
    chk("t1_busreq_latency", 64'(rq_cyc - if_gnt_cyc), 64'd1);
    chk("t1_bus_addr", 64'(rq_addr), 64'h100);
    chk("t1_bus_we_be", 64'({rq_we, rq_be}), 64'h0F);
    chk("t1_rv_latency", 64'(if_rv_cyc - if_gnt_cyc), 64'd4);
    chk("t1_rdata", 64'(last_if_rdata), 64'h13);
    chk("t1_ls_quiet", 64'(n_ls_gnt + n_ls_rv), 64'd0);

    // Simultaneous: LS store wins, IF follows the cycle after the ack
    #1;
    if_req = 1; if_addr = 32'h104; bus_val = 32'h0;
    drive_ls(1, 32'h2000, 32'hDEADBEEF, 4'h3);
    wait_ev(1, 10, "t2_lsgnt");
    #1 ls_req = 0;
    wait_ev(3, 10, "t2_lsrv");
    chk("t2_store_payload", {rq_we, rq_be, rq_addr}, {1'b1, 4'h3, 32'h2000});
    chk("t2_store_wdata", 64'(rq_wdata), 64'hDEADBEEF);
    chk("t2_if_none_yet", 64'(n_if_gnt), 64'd1);
    wait_ev(0, 10, "t2_ifgnt");
    chk("t2_if_after_ack", 64'(if_gnt_cyc - ls_rv_cyc), 64'd1);
    #1 if_req = 0;
    wait_ev(2, 10, "t2_ifrv");

    // Starvation: four LS wins, then IF is forced through
    #1;
    ls0 = n_ls_gnt;
    if_req = 1; if_addr = 32'h108;
    drive_ls(0, 32'h3000, '0, 4'hF);
    wait_ev(0, 100, "t3_ifgnt");
    chk("t3_ls_wins_before_if", 64'(n_ls_gnt - ls0), 64'd4);
    #1 if_req = 0;
    wait_ev(1, 20, "t3_lsgnt");
    #1 ls_req = 0;
    wait_ev(3, 20, "t3_lsrv");

    // Flush while a fetch waits for its response
    #1;
    if_req = 1; if_addr = 32'h200; bus_val = 32'hAAAA5555;
    rv0 = n_if_rv; bus0 = n_bus_rv;
    wait_ev(0, 10, "t4_gnt");
    #1 if_req = 0;
    repeat (2) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    repeat (4) @(posedge clk);
    chk("t4_fetch_dropped", 64'(n_if_rv - rv0), 64'd0);
    chk("t4_bus_consumed", 64'(n_bus_rv - bus0), 64'd1);
    #1;
    if_req = 1; if_addr = 32'h204; bus_val = 32'h0BADF00D;
    wait_ev(0, 10, "t4_gnt2");
    #1 if_req = 0;
    wait_ev(2, 10, "t4_rv2");
    chk("t4_next_fetch_data", 64'(last_if_rdata), 64'h0BADF00D);

    // Flush never drops an LS load; flush in IDLE lets only LS through
    #1;
    drive_ls(0, 32'h40, '0, 4'hF);
    bus_val = 32'h12345678;
    wait_ev(1, 10, "t5_gnt");
    #1 ls_req = 0;
    repeat (2) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    wait_ev(3, 10, "t5_rv");
    chk("t5_load_data", 64'(last_ls_rdata), 64'h12345678);
    #1;
    ls0 = n_ls_gnt; rv0 = n_if_gnt;
    flush = 1; if_req = 1; if_addr = 32'h300;
    drive_ls(1, 32'h44, 32'h1, 4'hF);
    @(posedge clk);
    chk("t5_flush_idle_ls", 64'(n_ls_gnt - ls0), 64'd1);
    chk("t5_flush_idle_no_if", 64'(n_if_gnt - rv0), 64'd0);
    #1 ls_req = 0; flush = 0;
    wait_ev(0, 20, "t5_ifgnt");
    #1 if_req = 0;
    wait_ev(2, 10, "t5_ifrv");

    // Stray bus_gnt/bus_rvalid while idle are ignored
    @(posedge clk); #2 spur = 1;
    @(posedge clk); #2 spur = 0;
    rv0 = n_if_rv + n_ls_rv;
    repeat (3) @(posedge clk);
    chk("spurious_ignored", 64'(n_if_rv + n_ls_rv - rv0), 64'd0);

    // Async reset while the address phase is stalled
    #1;
    drive_ls(1, 32'h80, 32'h55, 4'hF);
    hold_gnt = 1;
    wait_ev(1, 10, "t6_gnt");
    #1 ls_req = 0;
    @(posedge clk);
    #3;
    chk("t6_addr_phase", 64'({bus_req, arb_stall}), 64'h3);
    rst_n = 0;
    #1;
    chk("t6_reset_immediate", 64'(|{bus_req, bus_we, bus_addr, bus_wdata, bus_be, arb_stall,
        ls_gnt, if_gnt, ls_rvalid, if_rvalid}), 64'd0);
    hold_gnt = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // arb_stall covers the LS load from the cycle after its grant up to the response
    @(posedge clk); #1;
    st0 = n_stall; rv0 = n_ls_rv;
    drive_ls(0, 32'h90, '0, 4'hF);
    bus_val = 32'hCAFE0001;
    wait_ev(1, 10, "t7_gnt");
    #1 ls_req = 0;
    wait_ev(3, 10, "t7_rv");
    chk("t7_stall_cycles", 64'(n_stall - st0), 64'd3);
    repeat (3) @(posedge clk);
    chk("t7_stall_released", 64'(n_stall - st0), 64'd3);
    chk("t7_no_stale_resp", 64'(n_ls_rv - rv0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
